// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB master bridge.
// Holds the bridge state encoding, the read-data value returned for writes,
// and the APB4 PPROT encodings.
package apb_pkg;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;
  localparam apb_state_t ST_RESP   = 2'd3;

  // Every bit of rsp_rdata takes this value when a write completes
  localparam logic RDATA_ON_WRITE_BIT = 1'b0;

  // APB4 PPROT encodings: bit0 privileged, bit1 non-secure, bit2 instruction
  localparam logic [2:0] PPROT_NORMAL    = 3'b000;
  localparam logic [2:0] PPROT_PRIV      = 3'b001;
  localparam logic [2:0] PPROT_NONSECURE = 3'b010;
  localparam logic [2:0] PPROT_INSTR     = 3'b100;

  // A transfer is on the bus (psel high) in SETUP and ACCESS
  function automatic logic is_bus_phase(input apb_state_t s);
    return (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: ACCESS-phase wait counter for the APB master bridge.
// Counts cycles while enabled; expired is high in the cycle whose increment
// makes the count reach limit, so the caller can abort at that clock edge.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Wait-cycle counter: cleared at the start of each transfer, bumped per stalled cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && ((count + CNT_W'(1)) == limit);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts a valid/ready request/response channel into
// APB4 master transfers, one outstanding transfer at a time.
// Optional feature macro: APB_BRIDGE_TIMEOUT_EN aborts an ACCESS phase that
// waits TIMEOUT_CYCLES cycles without pready and reports it as an error.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int         ADDR_W         = 32,
  parameter int         DATA_W         = 32,
  parameter logic [2:0] PPROT_VAL      = PPROT_NORMAL,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_wen,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic [2:0]          pprot,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("apb_master_bridge: DATA_W must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_t state;
  apb_state_t state_next;
  logic       timeout_hit;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  apb_timeout_cnt #(
    .CNT_W (CNT_W)
  ) u_timeout_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ST_SETUP),
    .enable  ((state == ST_ACCESS) && !pready),
    .limit   (TIMEOUT_LIMIT),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: SETUP always leads to ACCESS, RESP always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid)            state_next = ST_SETUP;
      ST_SETUP:                            state_next = ST_ACCESS;
      ST_ACCESS: if (pready || timeout_hit) state_next = ST_RESP;
      ST_RESP:   if (rsp_ready)            state_next = ST_IDLE;
      default:                             state_next = ST_IDLE;
    endcase
  end

  // State register; reset drops psel/penable/rsp_valid immediately via the decode below
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // APB address/data/strobe registers, loaded when a request is accepted in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if ((state == ST_IDLE) && req_valid) begin
      paddr  <= req_addr;
      pwrite <= req_wen;
      pwdata <= req_wen ? req_wdata : '0;
      pstrb  <= req_wen ? req_wstrb : '0;
    end
  end

  // Response registers, captured on completion or abort and held through RESP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ST_ACCESS) begin
      if (pready) begin
        rsp_rdata <= pwrite ? {DATA_W{RDATA_ON_WRITE_BIT}} : prdata;
        rsp_err   <= pslverr;
      end else if (timeout_hit) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign psel      = is_bus_phase(state);
  assign penable   = (state == ST_ACCESS);
  assign rsp_valid = (state == ST_RESP);
  assign pprot     = PPROT_VAL;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts the core's simple valid/ready memory request/response channel into APB4 master transfers.
- Sits directly upstream of the APB delay stage: its APB master outputs drive that stage's APB slave inputs, and it consumes that stage's pready/prdata/pslverr.
- Handles one outstanding transfer at a time.
- Holds the response until the requester accepts it.

Parameters:
- ADDR_W, 32, request/APB address width.
- DATA_W, 32, data width (multiple of 8).
- PPROT_VAL, 3'b000, constant driven on pprot.
- TIMEOUT_CYCLES, 1024, ACCESS-phase cycles before abort; used only with the optional feature; must be >= 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge accepts request.
- req_addr  in  ADDR_W  byte address.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte enables for writes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  slave error or timeout.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pprot  out  3  equals PPROT_VAL.
- pwrite  out  1  APB write.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.
- pslverr  in  1  slave error.

Behaviour:
- Registered outputs:
  - All APB outputs, rsp_* and req_ready come from flops or decode directly from the state register.
  - No combinational path from pready or rsp_ready to any output.
- Reset values: psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE. req_ready=1 after reset (IDLE).
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid: latch addr/wen/wdata/wstrb into APB output regs, go to SETUP.
    - For reads, pstrb=0 and pwdata=0.
  - SETUP: psel=1, penable=0; unconditionally go to ACCESS next cycle.
  - ACCESS:
    - psel=1, penable=1; APB outputs stable.
    - On pready=1: capture rsp_rdata=prdata (read) or 0 (write), rsp_err=pslverr; drop psel/penable; go to RESP.
    - pslverr is sampled only when pready=1.
  - RESP:
    - rsp_valid=1, psel=0.
    - On rsp_ready: go to IDLE.
    - rsp_rdata/rsp_err stable while rsp_valid && !rsp_ready.
- Latency: request accepted in cycle N → psel rises in N+1, penable in N+2. pready=1 in cycle M → rsp_valid=1 in M+1. Minimum request-to-response is 3 cycles.
- req_ready=0 in SETUP/ACCESS/RESP. A new request is never accepted in the same cycle that a response is consumed; IDLE is always entered first.
- pready asserted while in SETUP is ignored.
- Reset mid-transfer: immediately psel=0, penable=0, rsp_valid=0; any pending response is discarded.
- DATA_W/8 strobe width; pprot is constant and not registered.

Optional Feature:
- Macro APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on SETUP entry and increments each ACCESS cycle without pready.
  - When it reaches TIMEOUT_CYCLES with pready still 0: abort (psel=0, penable=0), go to RESP with rsp_err=1, rsp_rdata=0.
  - pready in the same cycle as the limit wins: normal completion.
- Not defined: no counter logic; ACCESS waits indefinitely.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP), 2 bits.
  - localparam for the read-data-on-write value (0).
  - PPROT encodings.
- One natural sub-module: apb_timeout_cnt (clear, enable, limit → expired), instantiated only under APB_BRIDGE_TIMEOUT_EN.

Test Plan:
- Read, zero-wait: req addr=0x1000_0004, wen=0; slave pready=1 in first ACCESS with prdata=0xCAFE_F00D → psel at N+1, penable at N+2, rsp_valid at N+3, rsp_rdata=0xCAFEF00D, rsp_err=0, pstrb=0.
- Write, 5 wait states: addr=0x1000_0008, wdata=0x1234_5678, wstrb=4'b0011 → pwdata/pstrb/paddr stable for all 6 ACCESS cycles; rsp_rdata=0, rsp_err=0.
- Backpressure: pslverr=1 with pready; hold rsp_ready=0 for 4 cycles → rsp_valid, rsp_err=1 stable; req_ready=0 throughout; new req_valid is not accepted until the cycle after rsp_ready.
- Reset mid-ACCESS: assert reset during penable=1 → psel/penable/rsp_valid 0 asynchronously; after release req_ready=1, state IDLE.
- Timeout (macro on, TIMEOUT_CYCLES=8): pready held 0 → abort after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0. Repeat with pready=1 on the 8th cycle → normal completion, rsp_err=0.
- Back-to-back: req_valid held with rsp_ready=1 → each transfer separated by one IDLE cycle; SETUP always precedes ACCESS.
